msi_rr_arbiter: RTL

Parametrised N-channel round-robin arbiter: the registered, fair successor to the 4-to-2 priority encoder in the MSI library. Each cycle it samples a request vector and issues a held grant to one channel, as both a one-hot vector (decoder form) and a binary index with valid flag (encoder form). It sits in front of shared resources such as a mux/demux-selected bus, driving their select lines directly from `gnt_idx`.

---
 rtl/msi_pkg.sv | 13 +
 rtl/msi_rr_arbiter_if.sv | 29 ++
 rtl/msi_rr_pick.sv | 46 ++++
 rtl/msi_rr_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/msi_pkg.sv
// Shared definitions for the MSI round-robin arbiter: FSM state encoding,
// hold-limit default and hold-counter width.
package msi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int MAX_HOLD_DEF = 16;
    localparam int CNT_W        = 8;

endpackage

// File: rtl/msi_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface msi_rr_arbiter_if #(
    parameter int N = 4,
    parameter int W = $clog2(N)
);

    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [W-1:0] gnt_idx;
    logic         gnt_valid;
    logic         timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );

endinterface

// File: rtl/msi_rr_pick.sv
// Combinational rotate-priority encoder: first set req bit scanning from ptr
// upward with wrap, returned as one-hot, binary index and any-request flag.
module msi_rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] mask;
    logic [N-1:0] req_hi;
    logic [N-1:0] sel;

    genvar gi;
    genvar bi;

    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign mask[gi] = (ptr <= W'(gi));
        end
    endgenerate

    // Requests at or above ptr win; otherwise wrap to the lowest request overall.
    assign req_hi = req & mask;
    assign sel    = (|req_hi) ? req_hi : req;
    assign onehot = sel & (~sel + ONE);
    assign any    = |req;

    generate
        for (bi = 0; bi < W; bi++) begin : g_enc
            logic [N-1:0] col;
            for (gi = 0; gi < N; gi++) begin : g_col
                localparam bit IDX_BIT = ((gi >> bi) & 1) == 1;
                assign col[gi] = onehot[gi] & IDX_BIT;
            end
            assign idx[bi] = |col;
        end
    endgenerate

endmodule

// File: rtl/msi_rr_arbiter.sv
// N-channel round-robin arbiter with held, registered grants.
// Optional forced revocation after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module msi_rr_arbiter
    import msi_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = $clog2(N),
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    msi_rr_arbiter_if.slave  bus
);

    arb_state_t   state_reg, state_next;
    logic [W-1:0] ptr_reg, ptr_next;
    logic [W-1:0] idx_reg, idx_next;
    logic [N-1:0] gnt_reg, gnt_next;
    logic         valid_reg, valid_next;

    logic [W-1:0] wrap_ptr;
    logic [W-1:0] pick_ptr;
    logic [N-1:0] pick_onehot;
    logic [W-1:0] pick_idx;
    logic         pick_any;
    logic         held;
    logic         expire;
    logic         switch_now;

    assign held       = bus.req[idx_reg];
    assign wrap_ptr   = (idx_reg == W'(N - 1)) ? '0 : idx_reg + W'(1);
    assign switch_now = (state_reg == GRANT) && (!held || expire);

    // On a release the released channel moves to the back of the scan order.
    assign pick_ptr = switch_now ? wrap_ptr : ptr_reg;

    msi_rr_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req    (bus.req),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             timeout_reg, timeout_next;

    assign expire       = (state_reg == GRANT) && held &&
                          (cnt_reg == CNT_W'(MAX_HOLD - 1));
    assign timeout_next = expire;

    always_comb begin
        cnt_next = '0;
        if (state_reg == GRANT && !switch_now) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign bus.timeout = timeout_reg;
`else
    // The hold limit only has meaning when the timeout is built in.
    logic [CNT_W-1:0] unused_max_hold;
    assign unused_max_hold = CNT_W'(MAX_HOLD);
    assign expire          = 1'b0;
    assign bus.timeout     = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        gnt_next   = gnt_reg;
        idx_next   = idx_reg;
        valid_next = valid_reg;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    state_next = GRANT;
                    gnt_next   = pick_onehot;
                    idx_next   = pick_idx;
                    valid_next = 1'b1;
                end
            end
            GRANT: begin
                if (switch_now) begin
                    ptr_next = wrap_ptr;
                    if (pick_any) begin
                        gnt_next   = pick_onehot;
                        idx_next   = pick_idx;
                        valid_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                        gnt_next   = '0;
                        idx_next   = '0;
                        valid_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
                idx_next   = '0;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            gnt_reg   <= '0;
            idx_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            gnt_reg   <= gnt_next;
            idx_reg   <= idx_next;
            valid_reg <= valid_next;
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.gnt_idx   = idx_reg;
    assign bus.gnt_valid = valid_reg;

endmodule
